prbs_checker: RTL and testbench

Serial PRBS checker that sits directly downstream of `lfsr` and consumes its `d_out` stream one bit per enabled clock. It self-synchronises by loading its own history register from the incoming bits, verifies the stream against the configured polynomial, declares lock, and then counts bit errors. It is used to close the generator/checker loop in link and BIST benches, and is synthesizable for on-chip BIST.

---
 rtl/prbs_checker_pkg.sv | 20 ++
 rtl/prbs_predict.sv | 21 ++
 rtl/prbs_checker.sv | 145 ++++++++++++++
 tb/tb_prbs_checker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS generator/checker pair: FSM states and the
// default register length / feedback polynomial used by both ends of the link.
package prbs_checker_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_t;

  localparam int DEF_NUM_REG = 56;

  // x^56 + x^46 + x^23 + x^15 + x^12 + 1
  localparam logic [DEF_NUM_REG:0] DEF_POLY = 57'h100_4000_0080_9001;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prbs_predict.sv
// Combinational next-bit predictor: XOR of history taps selected by poly.
// h[k-1] is the bit from k enabled cycles ago; poly[k] selects tap x^k.
module prbs_predict
  import prbs_checker_pkg::*;
#(
  parameter int                 num_reg = DEF_NUM_REG,
  parameter logic [num_reg:0]   poly    = DEF_POLY
) (
  input  logic [num_reg-1:0] h,
  output logic               p
);

  // Fold every selected tap into the predicted bit.
  always_comb begin
    p = 1'b0;
    for (int unsigned k = 1; k <= num_reg; k++) begin
      if (poly[k]) p = p ^ h[k-1];
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: fills its history from the line,
// verifies a run of predictions, then free-runs on its own predictions while
// counting channel bit errors and dropping lock on a burst of errors.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int               num_reg   = DEF_NUM_REG,
  parameter logic [num_reg:0] poly      = DEF_POLY,
  parameter int               LOCK_CNT  = 16,
  parameter int               WINDOW    = 256,
  parameter int               ERR_LIMIT = 4,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             d_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned FILL_W = $clog2(max_u(num_reg, LOCK_CNT) + 1);
  localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
  localparam int unsigned WERR_W = $clog2(ERR_LIMIT + 1);

  prbs_state_t        state, state_n;
  logic [num_reg-1:0] h, h_n;
  logic [FILL_W-1:0]  fill_cnt, fill_cnt_n;
  logic [WIN_W-1:0]   win_cnt, win_cnt_n;
  logic [WERR_W-1:0]  win_err, win_err_n, win_err_inc;
  logic [CNT_W-1:0]   err_count_n;
  logic               err_pulse_n;
  logic               locked_n;
  logic               p;
  logic               mismatch;

  prbs_predict #(
    .num_reg (num_reg),
    .poly    (poly)
  ) u_predict (
    .h (h),
    .p (p)
  );

  assign mismatch = d_in ^ p;

  // Next-state and next-output logic; clear outranks enable.
  always_comb begin
    state_n     = state;
    h_n         = h;
    fill_cnt_n  = fill_cnt;
    win_cnt_n   = win_cnt;
    win_err_n   = win_err;
    win_err_inc = win_err;
    err_count_n = err_count;
    err_pulse_n = 1'b0;
    if (clear) begin
      state_n     = ST_HUNT;
      h_n         = '0;
      fill_cnt_n  = '0;
      win_cnt_n   = '0;
      win_err_n   = '0;
      err_count_n = '0;
    end else if (enable) begin
      case (state)
        ST_HUNT: begin
          h_n = {h[num_reg-2:0], d_in};
          if (fill_cnt == FILL_W'(num_reg - 1)) begin
            fill_cnt_n = '0;
            // An all-zero history is the LFSR lock-up state; keep hunting.
            if (h_n != '0) state_n = ST_VERIFY;
          end else begin
            fill_cnt_n = fill_cnt + 1'b1;
          end
        end
        ST_VERIFY: begin
          h_n = {h[num_reg-2:0], d_in};
          if (mismatch) begin
            state_n    = ST_HUNT;
            fill_cnt_n = '0;
          end else if (fill_cnt == FILL_W'(LOCK_CNT - 1)) begin
            state_n    = ST_LOCKED;
            fill_cnt_n = '0;
            win_cnt_n  = '0;
            win_err_n  = '0;
          end else begin
            fill_cnt_n = fill_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so one channel error costs one count.
          h_n         = {h[num_reg-2:0], p};
          win_err_inc = win_err + WERR_W'(mismatch);
          if (mismatch) begin
            err_pulse_n = 1'b1;
            if (err_count != '1) err_count_n = err_count + 1'b1;
          end
          if (win_err_inc == WERR_W'(ERR_LIMIT)) begin
            state_n    = ST_HUNT;
            fill_cnt_n = '0;
            win_cnt_n  = '0;
            win_err_n  = '0;
          end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
            win_cnt_n = '0;
            win_err_n = '0;
          end else begin
            win_cnt_n = win_cnt + 1'b1;
            win_err_n = win_err_inc;
          end
        end
        default: begin
          state_n    = ST_HUNT;
          fill_cnt_n = '0;
        end
      endcase
    end
    locked_n = (state_n == ST_LOCKED);
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= ST_HUNT;
      h         <= '0;
      fill_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      h         <= h_n;
      fill_cnt  <= fill_cnt_n;
      win_cnt   <= win_cnt_n;
      win_err   <= win_err_n;
      err_count <= err_count_n;
      err_pulse <= err_pulse_n;
      locked    <= locked_n;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a behavioural LFSR feeds the checker,
// with per-bit error injection, stuck-at-0 and gated-enable stimulus.
module tb_prbs_checker;

  localparam logic [56:0] POLY = 57'h100_4000_0080_9001;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        d_in = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  logic [55:0] g = 56'hA5C3_1F0E_9D27_64;
  int          nchecks = 0;
  int          nerrs = 0;

  prbs_checker #(
    .num_reg   (56),
    .poly      (POLY),
    .LOCK_CNT  (16),
    .WINDOW    (256),
    .ERR_LIMIT (4),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .res_n     (res_n),
    .enable    (enable),
    .clear     (clear),
    .d_in      (d_in),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic gen_next(input logic [55:0] s);
    logic b;
    b = 1'b0;
    for (int k = 1; k <= 56; k++) if (POLY[k]) b = b ^ s[k-1];
    return b;
  endfunction

  // One clock: drive inputs, take the edge, return 1 time unit after it.
  task automatic step(input logic en, input logic flip, input logic zero, input logic clr);
    logic b;
    b = 1'b0;
    if (en && !zero) begin
      b = gen_next(g);
      g = {g[54:0], b};
    end
    enable = en;
    clear  = clr;
    d_in   = zero ? 1'b0 : (b ^ flip);
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_lock(output int n);
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (locked) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nchecks++; if (locked !== 1'b0) begin nerrs++; $display("FAIL reset_locked got=%b exp=0", locked); end
    nchecks++; if (err_pulse !== 1'b0) begin nerrs++; $display("FAIL reset_pulse got=%b exp=0", err_pulse); end
    nchecks++; if (err_count !== 16'd0) begin nerrs++; $display("FAIL reset_count got=%0d exp=0", err_count); end
    #2 res_n = 1'b1;
  endtask

  task automatic test_clean_stream();
    int n, pulses, lost;
    run_to_lock(n);
    nchecks++; if (n !== 72) begin nerrs++; $display("FAIL clean_lock_bits got=%0d exp=72", n); end
    pulses = 0; lost = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (err_pulse) pulses++;
      if (!locked) lost++;
    end
    nchecks++; if (pulses !== 0) begin nerrs++; $display("FAIL clean_pulses got=%0d exp=0", pulses); end
    nchecks++; if (lost !== 0) begin nerrs++; $display("FAIL clean_unlocked_cycles got=%0d exp=0", lost); end
    nchecks++; if (err_count !== 16'd0) begin nerrs++; $display("FAIL clean_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_single_error();
    int pulses;
    repeat (300) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    nchecks++; if (err_pulse !== 1'b1) begin nerrs++; $display("FAIL single_pulse_now got=%b exp=1", err_pulse); end
    pulses = 1;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (err_pulse) pulses++;
    end
    nchecks++; if (pulses !== 1) begin nerrs++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
    nchecks++; if (err_count !== 16'd1) begin nerrs++; $display("FAIL single_count got=%0d exp=1", err_count); end
    nchecks++; if (locked !== 1'b1) begin nerrs++; $display("FAIL single_locked got=%b exp=1", locked); end
  endtask

  task automatic test_loss_of_lock();
    int n;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    run_to_lock(n);
    nchecks++; if (n !== 72) begin nerrs++; $display("FAIL lol_first_lock got=%0d exp=72", n); end
    for (int e = 1; e <= 4; e++) begin
      repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (e == 3) begin
        nchecks++; if (locked !== 1'b1) begin nerrs++; $display("FAIL lol_after3_locked got=%b exp=1", locked); end
      end
    end
    nchecks++; if (locked !== 1'b0) begin nerrs++; $display("FAIL lol_after4_locked got=%b exp=0", locked); end
    nchecks++; if (err_pulse !== 1'b1) begin nerrs++; $display("FAIL lol_after4_pulse got=%b exp=1", err_pulse); end
    nchecks++; if (err_count !== 16'd4) begin nerrs++; $display("FAIL lol_count got=%0d exp=4", err_count); end
    run_to_lock(n);
    nchecks++; if (n !== 72) begin nerrs++; $display("FAIL lol_relock_bits got=%0d exp=72", n); end
    nchecks++; if (err_count !== 16'd4) begin nerrs++; $display("FAIL lol_relock_count got=%0d exp=4", err_count); end
  endtask

  task automatic test_stuck();
    int lk;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    lk = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      if (locked) lk++;
    end
    nchecks++; if (lk !== 0) begin nerrs++; $display("FAIL stuck_locked_cycles got=%0d exp=0", lk); end
  endtask

  task automatic test_clear_priority();
    int n;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    run_to_lock(n);
    for (int e = 0; e < 3; e++) begin
      repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    nchecks++; if (err_count !== 16'd3) begin nerrs++; $display("FAIL clr_pre_count got=%0d exp=3", err_count); end
    nchecks++; if (locked !== 1'b1) begin nerrs++; $display("FAIL clr_pre_locked got=%b exp=1", locked); end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    nchecks++; if (locked !== 1'b0) begin nerrs++; $display("FAIL clr_locked got=%b exp=0", locked); end
    nchecks++; if (err_count !== 16'd0) begin nerrs++; $display("FAIL clr_count got=%0d exp=0", err_count); end
    nchecks++; if (err_pulse !== 1'b0) begin nerrs++; $display("FAIL clr_pulse got=%b exp=0", err_pulse); end
    // 56 fill bits, then 3 good verify bits, then a bad one at bit 60.
    repeat (59) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_to_lock(n);
    nchecks++; if (n !== 72) begin nerrs++; $display("FAIL verify_flip_relock got=%0d exp=72", n); end
  endtask

  task automatic test_gated_enable_and_reset();
    int en_bits, cyc_at, en_at, off_pulses;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    en_bits = 0; cyc_at = -1; en_at = -1; off_pulses = 0;
    for (int c = 1; c <= 400; c++) begin
      step(c[0], 1'b0, 1'b0, 1'b0);
      if (c[0]) en_bits++;
      else if (err_pulse) off_pulses++;
      if (locked) begin
        cyc_at = c;
        en_at = en_bits;
        break;
      end
    end
    nchecks++; if (en_at !== 72) begin nerrs++; $display("FAIL gated_lock_bits got=%0d exp=72", en_at); end
    nchecks++; if (cyc_at !== 143) begin nerrs++; $display("FAIL gated_lock_cycle got=%0d exp=143", cyc_at); end
    nchecks++; if (off_pulses !== 0) begin nerrs++; $display("FAIL gated_off_pulses got=%0d exp=0", off_pulses); end
    for (int e = 0; e < 4; e++) begin
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    repeat (60) step(1'b1, 1'b0, 1'b0, 1'b0);
    nchecks++; if (err_count !== 16'd4) begin nerrs++; $display("FAIL prerst_count got=%0d exp=4", err_count); end
    // Mid-VERIFY: assert reset between edges and look before the next edge.
    enable = 1'b0;
    #2 res_n = 1'b0;
    #1;
    nchecks++; if (err_count !== 16'd0) begin nerrs++; $display("FAIL async_rst_count got=%0d exp=0", err_count); end
    nchecks++; if (locked !== 1'b0) begin nerrs++; $display("FAIL async_rst_locked got=%b exp=0", locked); end
    nchecks++; if (err_pulse !== 1'b0) begin nerrs++; $display("FAIL async_rst_pulse got=%b exp=0", err_pulse); end
    @(negedge clk);
    res_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_stream();
    test_single_error();
    test_loss_of_lock();
    test_stuck();
    test_clear_priority();
    test_gated_enable_and_reset();
    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule
